// File: rtl/dff_out_monitor.sv
// rtl/dff_out_monitor.sv - edge monitor on a flop output with timestamped event FIFO and saturating edge counter
// Optional timestamp counter enabled by defining DFF_OUT_MONITOR_TIMESTAMP_EN.
module dff_out_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [8:0]       ev_data,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic             r_d_q;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [8:0]       r_mem [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic       w_rise;
  logic       w_fall;
  logic       w_edge;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [7:0] w_ts;

`ifdef DFF_OUT_MONITOR_TIMESTAMP_EN
  logic [7:0] r_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts <= 8'd0;
    end else if (clr) begin
      r_ts <= 8'd0;
    end else begin
      r_ts <= r_ts + 8'd1;
    end
  end

  assign w_ts = r_ts;
`else
  assign w_ts = 8'd0;
`endif

  assign w_rise = d & ~r_d_q;
  assign w_fall = ~d & r_d_q;
  assign w_edge = (w_rise & mode[0]) | (w_fall & mode[1]);

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop  = ~w_empty & ev_ready;
  assign w_push = w_edge & (~w_full | w_pop);
  assign w_drop = w_edge & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q <= 1'b0;
    end else begin
      r_d_q <= d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      if (w_edge && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the output mux hides it whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {w_rise, w_ts};
    end
  end

  assign ev_valid = ~w_empty;
  assign ev_data  = w_empty ? 9'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign ev_count = r_cnt;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_dff_out_monitor.sv
// tb/tb_dff_out_monitor.sv - directed self-checking bench for dff_out_monitor
module tb_dff_out_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       clr = 1'b0;
  logic       ev_ready = 1'b0;

  logic       ev_valid;
  logic [8:0] ev_data;
  logic [7:0] ev_count;
  logic       overflow;

  logic       ev_valid2;
  logic [8:0] ev_data2;
  logic [1:0] ev_count2;
  logic       overflow2;

  int n_vec  = 0;
  int n_miss = 0;

  dff_out_monitor #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .clr(clr),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .ev_count(ev_count), .overflow(overflow)
  );

  dff_out_monitor #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .clr(clr),
    .ev_valid(ev_valid2), .ev_ready(ev_ready), .ev_data(ev_data2),
    .ev_count(ev_count2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ev(input logic rise, input logic [7:0] ts);
`ifdef DFF_OUT_MONITOR_TIMESTAMP_EN
    return {rise, ts};
`else
    return {rise, 8'd0};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset, checks reset outputs, then releases on a falling edge so the next rising edge is edge 0.
  task automatic do_reset(input logic [1:0] m, input logic rdy, input logic d0);
    rst_n = 1'b0;
    mode = m;
    ev_ready = rdy;
    d = d0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", ev_valid, 0);
    check("rst_data", ev_data, 0);
    check("rst_count", ev_count, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // First detected rise at edge 3 after release.
    do_reset(2'b11, 1'b1, 1'b0);
    repeat (3) step();
    check("t1_pre_valid", ev_valid, 0);
    d = 1'b1;
    step();
    check("t1_valid", ev_valid, 1);
    check("t1_data", ev_data, ev(1'b1, 8'd3));
    check("t1_count", ev_count, 1);
    step();
    check("t1_popped", ev_valid, 0);

    // d=1 on the first edge after release is a rise.
    do_reset(2'b11, 1'b0, 1'b1);
    step();
    check("t2_valid", ev_valid, 1);
    check("t2_data", ev_data, ev(1'b1, 8'd0));
    check("t2_count", ev_count, 1);

    // Rise-only mode on a 0,1,0,1 toggle.
    do_reset(2'b01, 1'b0, 1'b0);
    d = 1'b0; step();
    d = 1'b1; step();
    d = 1'b0; step();
    d = 1'b1; step();
    check("t3_count", ev_count, 2);
    check("t3_head0", ev_data, ev(1'b1, 8'd1));
    ev_ready = 1'b1;
    step();
    check("t3_valid1", ev_valid, 1);
    check("t3_head1", ev_data, ev(1'b1, 8'd3));
    step();
    check("t3_empty", ev_valid, 0);
    check("t3_count_end", ev_count, 2);

    // Six edges with no consumer: four held, two dropped.
    do_reset(2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      d = (k % 2 == 0);
      step();
    end
    check("t4_count", ev_count, 6);
    check("t4_sat_count", ev_count2, 3);
    check("t4_ovf", overflow, 1);
    check("t4_head0", ev_data, ev(1'b1, 8'd0));
    ev_ready = 1'b1;
    step();
    check("t4_head1", ev_data, ev(1'b0, 8'd1));
    step();
    check("t4_head2", ev_data, ev(1'b1, 8'd2));
    step();
    check("t4_head3", ev_data, ev(1'b0, 8'd3));
    step();
    check("t4_empty", ev_valid, 0);
    check("t4_ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous pop and push.
    do_reset(2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      d = (k % 2 == 0);
      step();
    end
    check("t5_full_ovf", overflow, 0);
    ev_ready = 1'b1;
    d = 1'b1;
    step();
    check("t5_ovf", overflow, 0);
    check("t5_count", ev_count, 5);
    check("t5_head1", ev_data, ev(1'b0, 8'd1));
    step();
    check("t5_head2", ev_data, ev(1'b1, 8'd2));
    step();
    check("t5_head3", ev_data, ev(1'b0, 8'd3));
    step();
    check("t5_head4", ev_data, ev(1'b1, 8'd4));
    step();
    check("t5_empty", ev_valid, 0);

    // Saturation then synchronous clear; d_q keeps sampling during clr.
    do_reset(2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      d = (k % 2 == 0);
      step();
    end
    check("t6_sat", ev_count2, 3);
    check("t6_count", ev_count, 5);
    check("t6_ovf", overflow, 1);
    clr = 1'b1;
    d = 1'b0;
    step();
    check("t6_clr_count", ev_count, 0);
    check("t6_clr_sat", ev_count2, 0);
    check("t6_clr_ovf", overflow, 0);
    check("t6_clr_valid", ev_valid, 0);
    clr = 1'b0;
    step();
    check("t6_dq_sampled", ev_valid, 0);
    d = 1'b1;
    step();
    check("t6_post_valid", ev_valid, 1);
    check("t6_post_data", ev_data, ev(1'b1, 8'd1));
    check("t6_post_count", ev_count, 1);

    // Asynchronous reset mid-stream, then mode changes.
    do_reset(2'b11, 1'b0, 1'b0);
    d = 1'b1; step();
    d = 1'b0; step();
    check("t7_queued", ev_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t7_async_valid", ev_valid, 0);
    check("t7_async_data", ev_data, 0);
    check("t7_async_count", ev_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    step();
    step();
    check("t7_no_stale", ev_valid, 0);
    mode = 2'b00;
    d = 1'b1; step();
    d = 1'b0; step();
    check("t7_off_valid", ev_valid, 0);
    check("t7_off_count", ev_count, 0);
    mode = 2'b10;
    d = 1'b1; step();
    check("t7_fall_only_rise", ev_valid, 0);
    d = 1'b0; step();
    check("t7_fall_valid", ev_valid, 1);
    check("t7_fall_data", ev_data, ev(1'b0, 8'd5));
    check("t7_fall_count", ev_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dff_out_monitor.md
DFF_OUT_MONITOR -- requirements
Module: dff_out_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the edge counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port d  input  1  monitored signal, the output of the upstream flop primitive.
REQ-006 SHALL have port mode  input  2  edge select: 00 off, 01 rise, 10 fall, 11 both.
REQ-007 SHALL have port clr  input  1  synchronous clear.
REQ-008 SHALL have port ev_valid  output  1  event record available.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts the event.
REQ-010 SHALL have port ev_data  output  9  bit 8 is 1 for rise and 0 for fall; bits 7:0 are the timestamp.
REQ-011 SHALL have port ev_count  output  CNT_W  saturating count of detected edges.
REQ-012 SHALL have port overflow  output  1  sticky flag set when an event is dropped.

Function
REQ-013 SHALL register d into d_q every cycle, regardless of mode.
REQ-014 SHALL define edge detection at a clk edge as d != d_q: rise is d=1, fall is d=0; an edge counts only if mode selects it.
REQ-015 SHALL push a detected event into the FIFO at that same clk edge; ev_valid SHALL go high from the following cycle (latency 1, no bypass).
REQ-016 SHALL pop the FIFO head when ev_valid and ev_ready are both high; ev_data SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-017 SHALL maintain an 8-bit free-running timestamp incrementing every cycle, wrapping 255 to 0; the event captures its pre-increment value.
REQ-018 SHALL handle a push to a full FIFO without a same-cycle pop by dropping the event and setting overflow (sticky until clr or reset).
REQ-019 SHALL accept a push to a full FIFO when a pop occurs in the same cycle; occupancy stays DEPTH.
REQ-020 SHALL increment ev_count for every detected edge, dropped events included, saturating at all-ones.
REQ-021 SHALL, on clr=1, zero ev_count, overflow, FIFO pointers and timestamp at the next edge; clr takes priority over push and pop; d_q still samples d.
REQ-022 SHALL apply a mode change from the same cycle; in-flight FIFO entries are unaffected.
REQ-023 SHALL keep ev_valid low whenever the FIFO is empty; it never reflects an unpushed event.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear d_q, timestamp, FIFO pointers, ev_count and overflow to 0; ev_valid=0, ev_data=0.
REQ-025 SHALL release reset synchronously to clk; d=1 on the first edge after release SHALL register as a rise (d_q resets to 0).
REQ-026 SHALL discard in-flight FIFO entries when reset is asserted mid-operation.

Configuration
REQ-027 SHALL, with DFF_OUT_MONITOR_TIMESTAMP_EN defined, implement the timestamp counter and drive ev_data[7:0] from it.
REQ-028 SHALL, without DFF_OUT_MONITOR_TIMESTAMP_EN, omit the timestamp counter and drive ev_data[7:0] to constant 0; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover: reset, mode=11, ev_ready=1, d 0->1 at cycle 3 after release -> ev_valid high at cycle 4, ev_data=9'h103 (timestamp on), ev_count=1.
REQ-030 SHALL cover: mode=01, d toggles 0,1,0,1 on successive cycles -> exactly 2 events, both with bit 8=1, ev_count=2.
REQ-031 SHALL cover: ev_ready=0, mode=11, 6 edges with DEPTH=4 -> 4 events held, overflow=1, ev_count=6; then ev_ready=1 -> the 4 oldest events drain in order.
REQ-032 SHALL cover: FIFO full, ev_ready=1, new edge in the same cycle -> no drop, overflow stays 0.
REQ-033 SHALL cover: CNT_W=2, 5 edges -> ev_count saturates at 3; clr=1 -> ev_count=0, overflow=0, ev_valid=0 next cycle.
REQ-034 SHALL cover: rst_n pulsed low mid-stream with 2 entries queued -> ev_valid=0 immediately, and 0 queued events remain after release.
